// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel timing from the incoming sync edges and emits each
// active pixel as 4-bit grayscale with its (x, y) coordinate on a one-cycle strobe.
module vga_capture #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int H_ACTIVE_START = 144,
  parameter int H_ACTIVE       = 640,
  parameter int H_TOTAL        = 800,
  parameter int V_ACTIVE_START = 34,
  parameter int V_ACTIVE       = 480,
  parameter int V_TOTAL        = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] vga_r,
  input  logic [3:0] vga_g,
  input  logic [3:0] vga_b,
  input  logic       hsync,
  input  logic       vsync,
  output logic       pixel_valid,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [3:0] pixel_gray,
  output logic       frame_start,
  output logic       frame_done,
  output logic       locked
);

  localparam int PW = $clog2(CLKS_PER_PIXEL);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_PIXEL - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_PIXEL / 2);
  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] H_LO    = 10'(H_ACTIVE_START);
  localparam logic [9:0] H_HI    = 10'(H_ACTIVE_START + H_ACTIVE);
  localparam logic [9:0] V_LO    = 10'(V_ACTIVE_START);
  localparam logic [9:0] V_HI    = 10'(V_ACTIVE_START + V_ACTIVE);
  localparam logic [9:0] H_LOST  = 10'(H_TOTAL + 8);
  localparam logic [9:0] V_LOST  = 10'(V_TOTAL + 2);
  localparam logic [9:0] X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_ACTIVE - 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state;
  logic [3:0]    r_s1, g_s1, b_s1;
  logic          hs_s1, vs_s1, hs_s2, vs_s2;
  logic [PW-1:0] phase;
  logic [9:0]    h_count, v_count;
  logic          vs_pending, v_seen;

  logic       hs_fall, vs_fall, consume, h_active, v_active, sample, lost;
  logic [5:0] gray_sum;
  logic [9:0] x_rel, y_rel;

  assign hs_fall  = hs_s2 & ~hs_s1;
  assign vs_fall  = vs_s2 & ~vs_s1;
  assign consume  = hs_fall & vs_pending;
  assign h_active = (h_count >= H_LO) && (h_count < H_HI);
  assign v_active = (v_count >= V_LO) && (v_count < V_HI);
  assign sample   = (state == LOCKED) && (phase == PH_SAMPLE) && h_active && v_active;
  assign lost     = (h_count >= H_LOST) || (v_seen && (v_count >= V_LOST));
  assign gray_sum = {2'b00, r_s1} + {1'b0, g_s1, 1'b0} + {2'b00, b_s1};
  assign x_rel    = h_count - H_LO;
  assign y_rel    = v_count - V_LO;

  // The lock state is the only FSM state, so locked doubles as its debug view.
  assign locked = (state == LOCKED);

  // pixel_valid is a bare strobe: no backpressure, consumers must take every pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= UNLOCKED;
      r_s1        <= '0;
      g_s1        <= '0;
      b_s1        <= '0;
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
      hs_s2       <= 1'b0;
      vs_s2       <= 1'b0;
      phase       <= '0;
      h_count     <= '0;
      v_count     <= '0;
      vs_pending  <= 1'b0;
      v_seen      <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_gray  <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_s1  <= vga_r;
      g_s1  <= vga_g;
      b_s1  <= vga_b;
      hs_s1 <= hsync;
      vs_s1 <= vsync;
      hs_s2 <= hs_s1;
      vs_s2 <= vs_s1;

      if (hs_fall) begin
        phase   <= '0;
        h_count <= '0;
      end else if (phase == PH_LAST) begin
        phase <= '0;
        if (h_count != CNT_MAX) h_count <= h_count + 10'd1;
      end else begin
        phase <= phase + PW'(1);
      end

      if (hs_fall) begin
        if (vs_pending) begin
          v_count <= '0;
          v_seen  <= 1'b1;
        end else if (v_count != CNT_MAX) begin
          v_count <= v_count + 10'd1;
        end
      end

      // A vsync fall in the same cycle as the consuming hsync fall re-arms the flag.
      if (vs_fall)      vs_pending <= 1'b1;
      else if (consume) vs_pending <= 1'b0;

      case (state)
        UNLOCKED: if (consume) state <= LOCKED;
        LOCKED:   if (lost)    state <= UNLOCKED;
        default:               state <= UNLOCKED;
      endcase

      pixel_valid <= sample;
      frame_start <= sample && (x_rel == 10'd0) && (y_rel == 10'd0);
      frame_done  <= sample && (x_rel == X_LAST) && (y_rel == Y_LAST);
      if (sample) begin
        pixel_x    <= x_rel;
        pixel_y    <= y_rel;
        pixel_gray <= gray_sum[5:2];
      end
    end
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA output path: samples an incoming 640x480@60 VGA stream (4-bit RGB, active-low hsync/vsync) on the system clock and recovers pixel timing from the sync edges. Converts each active pixel to 4-bit grayscale and emits it with its (x, y) coordinate as a one-cycle strobe. Feeds frame buffers and convolution stages, and loops back the VGA output for self-test.

## Interface
- CLKS_PER_PIXEL, 4: system clocks per pixel; even, at least 2.
- H_ACTIVE_START, 144: pixel index after the hsync falling edge where active video begins (sync 96 + back porch 48).
- H_ACTIVE, 640: active pixels per line.
- H_TOTAL, 800: pixels per line; used for loss-of-sync detection.
- V_ACTIVE_START, 34: line count after the vsync-qualified hsync edge where active video begins.
- V_ACTIVE, 480: active lines.
- V_TOTAL, 525: lines per frame.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vga_r, vga_g, vga_b  in  4 each  incoming colour, same-clock-domain.
- hsync, vsync  in  1 each  active-low sync.
- pixel_valid  out  1  one-cycle strobe; pixel_x/pixel_y/pixel_gray valid.
- pixel_x  out  10  active column 0..639.
- pixel_y  out  10  active row 0..479.
- pixel_gray  out  4  (r + 2g + b) >> 2.
- frame_start  out  1  pulses with pixel_valid for pixel (0,0).
- frame_done  out  1  pulses with pixel_valid for pixel (639,479).
- locked  out  1  high while horizontal and vertical timing is tracked.

## Operation
- Input stage: all VGA inputs are registered once (stage 1), then hsync/vsync are registered again (stage 2). A falling edge is stage2 high and stage1 low.
- Horizontal tracker:
  - On an hsync fall: phase <= 0 and h_count <= 0.
  - Otherwise phase increments; when it wraps at CLKS_PER_PIXEL-1, h_count increments, saturating at 1023.
- Vertical tracker:
  - A vsync fall sets vs_pending.
  - The next hsync fall sets v_count <= 0 and clears vs_pending, and sets v_seen.
  - Any other hsync fall increments v_count, saturating at 1023.
- States: UNLOCKED and LOCKED.
  - UNLOCKED -> LOCKED on the first hsync fall that consumes vs_pending.
  - LOCKED -> UNLOCKED when h_count reaches H_TOTAL+8 (hsync lost) or v_count reaches V_TOTAL+2 (vsync lost). The counters keep running.
  - locked = (state == LOCKED).
- Sample point: phase == CLKS_PER_PIXEL/2. Conditions: LOCKED, h_count in [H_ACTIVE_START, H_ACTIVE_START+H_ACTIVE), and v_count in [V_ACTIVE_START, V_ACTIVE_START+V_ACTIVE).
  - pixel_x = h_count - H_ACTIVE_START.
  - pixel_y = v_count - V_ACTIVE_START.
  - pixel_gray = 6-bit sum (r + 2g + b) of the stage-1 colour, shifted right by 2 (truncate).
- An hsync fall and a vsync fall in the same cycle: both take effect. The hsync fall does not consume a vs_pending set in that same cycle.
- A hsync fall mid-line resynchronises immediately; a partial line is not padded.
- Outputs hold their last values between strobes.

## Timing
- Reset: state UNLOCKED; phase, h_count, v_count, vs_pending, v_seen = 0; all outputs 0.
- An hsync fall on the pins appears at the edge detector 2 cycles later. The tracker updates on that same edge.
- Pixel k of a line is sampled (k+H_ACTIVE_START)*CLKS_PER_PIXEL + CLKS_PER_PIXEL/2 cycles after the hsync-fall detection cycle. pixel_valid is registered and asserts the following cycle.
- With defaults, strobes are exactly 4 cycles apart within a line. There are 640 strobes per line and 307200 per frame.
- frame_start and frame_done coincide with their pixel_valid; they are never asserted otherwise.
- Transition to UNLOCKED suppresses pixel_valid from the next sample point onward.

## Test plan
- Reset mid-frame: assert reset with stream running -> locked=0 and pixel_valid=0 the same cycle. After release, no strobe before a vsync fall followed by an hsync fall.
- Full frame of loopback from the VGA output block with colour r=g=b=x mod 16 -> exactly 307200 strobes, one frame_start at (0,0) and one frame_done at (639,479), and pixel_gray == pixel_x mod 16.
- Gray arithmetic: r=15, g=0, b=15 -> gray 7; r=0, g=15, b=0 -> gray 7; r=g=b=15 -> gray 15.
- Line timing: after an hsync-fall detection at cycle T, the first strobe has x=0 at cycle T+579, the last has x=639 at T+3135, and consecutive strobes are 4 cycles apart.
- Hsync removal: hold hsync high while locked -> locked falls when h_count = 808, with no strobes afterwards. Restoring the sync stream relocks after the next vsync.
- Simultaneous hsync/vsync fall in one cycle -> v_count increments (not zeroed). The following hsync fall zeroes v_count, and the first active line has y=0 at v_count 34.
